// File: rtl/tmp_pkg.sv
// Shared definitions for the temperature bitstream decimator.
//   tmp_state_e     : decimator FSM state encoding (IDLE, SETTLE, ACCUM)
//   TMP_LOG2_N      : default log2 of decisions per conversion window
//   TMP_N_DISCARD   : default number of decisions discarded before a window
//   TMP_SYNC_STAGES : default synchroniser depth on the toggle inputs
package tmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2
  } tmp_state_e;

  localparam int TMP_LOG2_N      = 6;
  localparam int TMP_N_DISCARD   = 4;
  localparam int TMP_SYNC_STAGES = 2;

endpackage

// File: rtl/tmp_tgl_det.sv
// Toggle-to-pulse converter for one charge-pump decision input.
// The asynchronous toggle level passes a SYNC_STAGES-deep synchroniser, is
// compared with its own one-cycle-delayed copy, and the difference is
// registered, so a level change shows up as a one-cycle evt pulse
// SYNC_STAGES+1 cycles after the input edge.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   tgl_in  : asynchronous toggle input (each level change = one decision)
//   evt     : one-cycle pulse per detected level change
module tmp_tgl_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tgl_in,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   evt_q, evt_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tgl_in};
    prev_d = sync_q[SYNC_STAGES-1];
    evt_d  = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  // Reset loads the present input level everywhere so that a toggle input
  // sitting high through reset does not produce a phantom decision.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{tgl_in}};
      prev_q <= tgl_in;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/tmp_bitstream_decimator.sv
// sinc1 decimator for the temperature-sensor charge-pump decision stream.
// Each src/snk toggle is one decision; over a window of 2^LOG2_N decisions
// the number of source decisions is counted and presented as a code.
//   clk, reset_n : clock and synchronous active-low reset
//   enable       : conversion enable; low aborts to IDLE
//   setup_bias   : controller bias-setup phase; decisions ignored while high
//   src_tgl      : source-decision toggle input
//   snk_tgl      : sink-decision toggle input
//   clr_flags    : one-cycle clear of overrun/collision
//   code         : src decisions in the last completed window (0..N)
//   code_valid   : code holds an unconsumed result
//   code_ready   : consumer ready
//   busy         : FSM not in IDLE
//   overrun      : sticky, a window result was dropped
//   collision    : sticky, src and snk decisions seen in the same cycle
//
// Handshake: code is transferred on every rising clock edge where
// code_valid && code_ready; code_valid then falls unless a new window
// completes on that same edge, in which case the new result replaces it
// and code_valid stays high. code never changes while code_valid is high
// and no transfer happens.
module tmp_bitstream_decimator
  import tmp_pkg::*;
#(
  parameter int LOG2_N      = TMP_LOG2_N,
  parameter int N_DISCARD   = TMP_N_DISCARD,
  parameter int SYNC_STAGES = TMP_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              setup_bias,
  input  logic              src_tgl,
  input  logic              snk_tgl,
  input  logic              clr_flags,
  output logic [LOG2_N:0]   code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              overrun,
  output logic              collision
);

  localparam int              CW       = LOG2_N + 1;
  localparam logic [CW-1:0]   N_VAL    = CW'(1 << LOG2_N);
  localparam logic [3:0]      DISC_VAL = 4'(N_DISCARD);

  tmp_state_e    state_q, state_d;
  logic [3:0]    disc_cnt_q, disc_cnt_d;
  logic [CW-1:0] tot_cnt_q, tot_cnt_d;
  logic [CW-1:0] src_cnt_q, src_cnt_d;
  logic [CW-1:0] code_q, code_d;
  logic          code_valid_q, code_valid_d;
  logic          overrun_q, overrun_d;
  logic          collision_q, collision_d;

  logic          src_evt, snk_evt;
  logic          count_evt;
  logic          window_done;
  logic [CW-1:0] result;
  logic          handshake;
  logic          overrun_set;
  logic          collision_set;

  tmp_tgl_det #(.SYNC_STAGES(SYNC_STAGES)) u_src_det (
    .clk     (clk),
    .reset_n (reset_n),
    .tgl_in  (src_tgl),
    .evt     (src_evt)
  );

  tmp_tgl_det #(.SYNC_STAGES(SYNC_STAGES)) u_snk_det (
    .clk     (clk),
    .reset_n (reset_n),
    .tgl_in  (snk_tgl),
    .evt     (snk_evt)
  );

  // FSM and window counters. A decision counts only when exactly one of the
  // two pulses is present; simultaneous pulses are ambiguous and dropped.
  always_comb begin
    state_d     = state_q;
    disc_cnt_d  = disc_cnt_q;
    tot_cnt_d   = tot_cnt_q;
    src_cnt_d   = src_cnt_q;
    window_done = 1'b0;
    result      = '0;
    count_evt   = (src_evt ^ snk_evt) & ~setup_bias;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = SETTLE;
          disc_cnt_d = '0;
        end
      end

      SETTLE: begin
        if (!enable) begin
          state_d    = IDLE;
          disc_cnt_d = '0;
        end else if (setup_bias) begin
          disc_cnt_d = '0;
        end else if (N_DISCARD == 0) begin
          state_d   = ACCUM;
          tot_cnt_d = '0;
          src_cnt_d = '0;
        end else if (count_evt) begin
          if (disc_cnt_q + 4'd1 == DISC_VAL) begin
            state_d    = ACCUM;
            disc_cnt_d = '0;
            tot_cnt_d  = '0;
            src_cnt_d  = '0;
          end else begin
            disc_cnt_d = disc_cnt_q + 4'd1;
          end
        end
      end

      ACCUM: begin
        if (!enable) begin
          state_d   = IDLE;
          tot_cnt_d = '0;
          src_cnt_d = '0;
        end else if (setup_bias) begin
          state_d    = SETTLE;
          disc_cnt_d = '0;
          tot_cnt_d  = '0;
          src_cnt_d  = '0;
        end else if (count_evt) begin
          if (tot_cnt_q + CW'(1) == N_VAL) begin
            // Last decision of the window: fold it into the result and
            // start the next window on the following cycle with no gap.
            window_done = 1'b1;
            result      = src_cnt_q + CW'(src_evt);
            tot_cnt_d   = '0;
            src_cnt_d   = '0;
          end else begin
            tot_cnt_d = tot_cnt_q + CW'(1);
            src_cnt_d = src_cnt_q + CW'(src_evt);
          end
        end
      end

      default: begin
        state_d    = IDLE;
        disc_cnt_d = '0;
        tot_cnt_d  = '0;
        src_cnt_d  = '0;
      end
    endcase
  end

  // Output register and sticky flags. A transfer on the completion edge
  // frees the slot, so the new result is accepted rather than dropped.
  always_comb begin
    handshake     = code_valid_q & code_ready;
    code_d        = code_q;
    code_valid_d  = code_valid_q;
    overrun_set   = 1'b0;
    collision_set = src_evt & snk_evt;

    if (window_done) begin
      if (!code_valid_q || handshake) begin
        code_d       = result;
        code_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (handshake) begin
      code_valid_d = 1'b0;
    end

    // Setting wins over a simultaneous clear.
    overrun_d   = (overrun_q & ~clr_flags) | overrun_set;
    collision_d = (collision_q & ~clr_flags) | collision_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      disc_cnt_q   <= '0;
      tot_cnt_q    <= '0;
      src_cnt_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      disc_cnt_q   <= disc_cnt_d;
      tot_cnt_q    <= tot_cnt_d;
      src_cnt_q    <= src_cnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      overrun_q    <= overrun_d;
      collision_q  <= collision_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;
  assign collision  = collision_q;

endmodule

// File: tb/tb_tmp_bitstream_decimator.sv
// Bench for tmp_bitstream_decimator (LOG2_N=4, N_DISCARD=2, SYNC_STAGES=2).
// A table of whole windows with expected codes, hand-written corner-case
// sequences, and a randomized run, all shadowed cycle by cycle by a
// decision-list reference model.
module tb_tmp_bitstream_decimator;

  localparam int LOG2_N      = 4;
  localparam int N_DISCARD   = 2;
  localparam int SYNC_STAGES = 2;
  localparam int N           = 16;
  localparam int CW          = LOG2_N + 1;
  // Edges from a toggle change until its decision is acted upon.
  localparam int EVT_DELAY   = SYNC_STAGES + 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          enable     = 1'b0;
  logic          setup_bias = 1'b0;
  logic          src_tgl    = 1'b1;
  logic          snk_tgl    = 1'b0;
  logic          clr_flags  = 1'b0;
  logic          code_ready = 1'b0;
  logic [CW-1:0] code;
  logic          code_valid;
  logic          busy;
  logic          overrun;
  logic          collision;

  always #5 clk = ~clk;

  tmp_bitstream_decimator #(
    .LOG2_N      (LOG2_N),
    .N_DISCARD   (N_DISCARD),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .setup_bias (setup_bias),
    .src_tgl    (src_tgl),
    .snk_tgl    (snk_tgl),
    .clr_flags  (clr_flags),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .busy       (busy),
    .overrun    (overrun),
    .collision  (collision)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_q[$];   // expected codes of consumed results
  logic [CW-1:0] obs_q[$];   // codes actually transferred by the DUT

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 discarding, 2 accumulating
  int            m_phase;
  int            m_disc_left;
  bit            m_win[$];      // decisions of the current window, 1 = src
  logic [CW-1:0] m_code;
  bit            m_valid;
  bit            m_over;
  bit            m_coll;
  logic [1:0]    pipe_q[$];     // {src,snk} toggles in flight to the DUT

  task automatic model_reset();
    m_phase = 0; m_disc_left = 0; m_win.delete();
    m_code = '0; m_valid = 0; m_over = 0; m_coll = 0;
    pipe_q.delete();
  endtask

  task automatic model_step(input bit s, input bit k);
    bit single;
    bit hs;
    bit done;
    bit over_set;
    int res;
    single   = s ^ k;
    hs       = m_valid && code_ready;
    done     = 0;
    over_set = 0;
    res      = 0;
    case (m_phase)
      0: if (enable) begin m_phase = 1; m_disc_left = N_DISCARD; end
      1: begin
        if (!enable) m_phase = 0;
        else if (setup_bias) m_disc_left = N_DISCARD;
        else if (m_disc_left == 0) begin m_phase = 2; m_win.delete(); end
        else if (single) begin
          m_disc_left--;
          if (m_disc_left == 0) begin m_phase = 2; m_win.delete(); end
        end
      end
      default: begin
        if (!enable) begin m_phase = 0; m_win.delete(); end
        else if (setup_bias) begin m_phase = 1; m_disc_left = N_DISCARD; m_win.delete(); end
        else if (single) begin
          m_win.push_back(s);
          if (m_win.size() == N) begin
            foreach (m_win[i]) res += int'(m_win[i]);
            done = 1;
            m_win.delete();
          end
        end
      end
    endcase
    if (hs) exp_q.push_back(m_code);
    if (done) begin
      if (!m_valid || hs) begin m_code = CW'(res); m_valid = 1; end
      else over_set = 1;
    end else if (hs) m_valid = 0;
    if (clr_flags) begin m_over = 0; m_coll = 0; end
    if (over_set) m_over = 1;
    if (s && k) m_coll = 1;
  endtask

  task automatic check_outputs();
    chk("code", code, m_code);
    chk("code_valid", code_valid, m_valid);
    chk("busy", busy, m_phase != 0);
    chk("overrun", overrun, m_over);
    chk("collision", collision, m_coll);
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: optionally flip toggles, advance DUT and model, check.
  task automatic tick(input bit s, input bit k);
    logic [1:0] eff;
    @(negedge clk);
    if (s) src_tgl = ~src_tgl;
    if (k) snk_tgl = ~snk_tgl;
    pipe_q.push_back({s, k});
    if (code_valid && code_ready) obs_q.push_back(code);
    @(posedge clk);
    eff = 2'b00;
    if (pipe_q.size() == EVT_DELAY) eff = pipe_q.pop_front();
    model_step(eff[1], eff[0]);
    #1;
    check_outputs();
  endtask

  task automatic send_decisions(input int n_src, input int n_snk, input bit alt);
    int  s_left;
    int  k_left;
    bit  turn;
    bit  pick_s;
    s_left = n_src;
    k_left = n_snk;
    turn   = 1;
    while (s_left + k_left > 0) begin
      if (alt) begin
        pick_s = (turn && s_left > 0) || k_left == 0;
        turn   = ~turn;
      end else begin
        pick_s = s_left > 0;
      end
      if (pick_s) begin tick(1, 0); s_left--; end
      else begin tick(0, 1); k_left--; end
      if ($urandom_range(0, 3) == 0) tick(0, 0);
    end
  endtask

  task automatic drain();
    repeat (6) tick(0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic chk_single_result(input string name, input logic [CW-1:0] exp);
    logic [CW-1:0] got;
    got = (obs_q.size() > 0) ? obs_q[0] : '1;
    chk({name, "_count"}, obs_q.size(), 1);
    chk({name, "_code"}, got, exp);
    obs_q.delete();
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    int            n_src;
    int            n_snk;
    bit            alt;
    logic [CW-1:0] exp_code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [CW-1:0] e;
    bit            slow;
    int            r;

    vecs[0] = '{8, 8, 1'b1, 5'd8};
    vecs[1] = '{12, 4, 1'b0, 5'd12};
    vecs[2] = '{16, 0, 1'b0, 5'd16};
    vecs[3] = '{0, 16, 1'b0, 5'd0};
    vecs[4] = '{5, 11, 1'b1, 5'd5};
    vecs[5] = '{11, 5, 1'b1, 5'd11};

    // Reset with src_tgl held high: no event afterwards.
    model_reset();
    do_reset();
    @(posedge clk); #1;
    chk("rst_code", code, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_collision", collision, 0);
    chk("rst_no_evt", dut.src_evt, 0);

    // First src edge: pulse exactly 3 cycles later, one cycle wide.
    @(negedge clk);
    src_tgl = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk("src_evt_latency", dut.src_evt, (i == SYNC_STAGES + 1));
    end

    // Table-driven windows with the consumer always ready.
    code_ready = 1'b1;
    enable     = 1'b1;
    tick(0, 0);
    send_decisions(0, N_DISCARD, 0);
    foreach (vecs[v]) begin
      obs_q.delete();
      send_decisions(vecs[v].n_src, vecs[v].n_snk, vecs[v].alt);
      drain();
      chk_single_result("tbl", vecs[v].exp_code);
    end

    // Two windows without a consumer: first result held, second dropped.
    code_ready = 1'b0;
    send_decisions(5, 11, 1);
    send_decisions(9, 7, 1);
    drain();
    chk("ovr_code", code, 5);
    chk("ovr_valid", code_valid, 1);
    chk("ovr_flag", overrun, 1);
    clr_flags = 1'b1;
    tick(0, 0);
    clr_flags = 1'b0;
    chk("ovr_cleared", overrun, 0);
    obs_q.delete();
    code_ready = 1'b1;
    tick(0, 0);
    code_ready = 1'b0;
    chk("ovr_consumed_valid", code_valid, 0);
    chk_single_result("ovr_xfer", 5);

    // Window completion on the same edge as the previous result's transfer.
    send_decisions(10, 6, 1);
    drain();
    chk("coin_first_code", code, 10);
    chk("coin_first_valid", code_valid, 1);
    send_decisions(7, 8, 1);
    tick(0, 1);
    repeat (EVT_DELAY - 2) tick(0, 0);
    code_ready = 1'b1;
    tick(0, 0);
    code_ready = 1'b0;
    chk("coin_code", code, 7);
    chk("coin_valid", code_valid, 1);
    chk("coin_overrun", overrun, 0);
    obs_q.delete();
    code_ready = 1'b1;
    tick(0, 0);
    chk_single_result("coin_xfer", 7);

    // Simultaneous src/snk mid-window: flagged, not counted.
    send_decisions(3, 2, 1);
    tick(1, 1);
    send_decisions(6, 5, 1);
    drain();
    chk("coll_flag", collision, 1);
    chk_single_result("coll", 9);
    clr_flags = 1'b1;
    tick(0, 0);
    clr_flags = 1'b0;
    chk("coll_cleared", collision, 0);

    // setup_bias after 9 events: partial window discarded, discard restarts.
    send_decisions(5, 4, 1);
    drain();
    setup_bias = 1'b1;
    tick(0, 0);
    tick(0, 0);
    setup_bias = 1'b0;
    send_decisions(0, N_DISCARD, 0);
    send_decisions(6, 10, 1);
    drain();
    chk_single_result("bias", 6);

    // enable dropped mid-window: idle, previous result still readable.
    code_ready = 1'b0;
    send_decisions(11, 5, 1);
    drain();
    send_decisions(3, 2, 1);
    drain();
    enable = 1'b0;
    tick(0, 0);
    chk("dis_busy", busy, 0);
    chk("dis_valid", code_valid, 1);
    chk("dis_code", code, 11);
    code_ready = 1'b1;
    tick(0, 0);
    code_ready = 1'b0;
    chk("dis_consumed", code_valid, 0);

    // Randomized run against the model; consumed codes go through exp_q.
    exp_q.delete();
    obs_q.delete();
    slow = 0;
    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 299) != 0);
      setup_bias = ($urandom_range(0, 79) == 0);
      clr_flags  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) slow = ~slow;
      code_ready = slow ? 1'b0 : 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      if (r == 19) tick(1, 1);
      else tick(r < 9, r >= 9 && r < 16);
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rand_xfer", obs_q.pop_front(), e);
      end
    end
    clr_flags  = 1'b0;
    setup_bias = 1'b0;
    code_ready = 1'b0;
    chk("rand_leftover", obs_q.size() + exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
